// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register addresses, ExcCodes, handler vector, FSM encoding.
// Imported by the write controller and the read-address mux so both agree on addresses.
package cp0_pkg;

    localparam logic [4:0]  CP0_ADDR_COUNT  = 5'd9;
    localparam logic [4:0]  CP0_ADDR_STATUS = 5'd12;
    localparam logic [4:0]  CP0_ADDR_CAUSE  = 5'd13;
    localparam logic [4:0]  CP0_ADDR_EPC    = 5'd14;

    localparam logic [4:0]  EXC_SYSCALL     = 5'd8;
    localparam logic [4:0]  EXC_BREAK       = 5'd9;
    localparam logic [4:0]  EXC_TEQ         = 5'd13;

    localparam logic [31:0] CP0_EXC_VECTOR  = 32'h0000_0004;
    localparam logic [31:0] CP0_STATUS_RST  = 32'h0000_0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXC_SAVE,
        ST_EXC_MASK,
        ST_ERET_RESTORE,
        ST_DONE
    } cp0_state_e;

    // Unknown codes are treated as masked so they never corrupt EPC/STATUS.
    function automatic logic exc_enabled(input logic [31:0] status, input logic [4:0] code);
        logic en;
        case (code)
            EXC_SYSCALL: en = status[0] & status[8];
            EXC_BREAK:   en = status[0] & status[9];
            EXC_TEQ:     en = status[3];
            default:     en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/cp0_write_ctrl.sv
// CP0 write side: mtc0 writes, exception entry and eret for STATUS/CAUSE/EPC (COUNT with CP0_COUNT_EN).
// Latency: mtc0 next edge; exception 3 cycles to EXC_DONE, eret 2, masked exception 1.
// Backpressure: requests are held levels; BUSY is high outside IDLE and mtc0 is dropped while busy.
module cp0_write_ctrl
    import cp0_pkg::*;
#(
    parameter logic [4:0]  ADDR_STATUS  = CP0_ADDR_STATUS,
    parameter logic [4:0]  ADDR_CAUSE   = CP0_ADDR_CAUSE,
    parameter logic [4:0]  ADDR_EPC     = CP0_ADDR_EPC,
    parameter logic [31:0] STATUS_RESET = CP0_STATUS_RST
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MTC0,
    input  logic [4:0]  CP0_W_ADDR,
    input  logic [31:0] CP0_W_DATA,
    input  logic        EXC_REQ,
    input  logic [4:0]  EXC_CODE,
    input  logic [31:0] EXC_PC,
    input  logic        ERET,
    input  logic [4:0]  CP0_R_ADDR,
    output logic [31:0] CP0_R_DATA,
    output logic [31:0] EPC_OUT,
    output logic [31:0] EXC_ADDR,
    output logic        EXC_DONE,
    output logic        BUSY
);

    cp0_state_e  state, next_state;
    logic        mtc0_we;
    logic [31:0] status, cause, epc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        mtc0_we    = 1'b0;
        EXC_DONE   = 1'b0;
        BUSY       = 1'b1;
        case (state)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (EXC_REQ)
                    next_state = exc_enabled(status, EXC_CODE) ? ST_EXC_SAVE : ST_DONE;
                else if (ERET)
                    next_state = ST_ERET_RESTORE;
                else
                    mtc0_we = MTC0;
            end
            ST_EXC_SAVE:     next_state = ST_EXC_MASK;
            ST_EXC_MASK:     next_state = ST_DONE;
            ST_ERET_RESTORE: next_state = ST_DONE;
            ST_DONE: begin
                EXC_DONE   = 1'b1;
                next_state = ST_IDLE;
            end
            default:         next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            status <= STATUS_RESET;
            cause  <= '0;
            epc    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mtc0_we && CP0_W_ADDR == ADDR_STATUS) status <= CP0_W_DATA;
                    if (mtc0_we && CP0_W_ADDR == ADDR_CAUSE)  cause  <= CP0_W_DATA;
                    if (mtc0_we && CP0_W_ADDR == ADDR_EPC)    epc    <= CP0_W_DATA;
                end
                ST_EXC_SAVE: begin
                    epc        <= EXC_PC;
                    cause[6:2] <= EXC_CODE;
                end
                ST_EXC_MASK:     status <= status << 5;
                ST_ERET_RESTORE: status <= status >> 5;
                default: ;
            endcase
        end
    end

`ifdef CP0_COUNT_EN
    logic [31:0] count;

    // An mtc0 to COUNT replaces that cycle's increment.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            count <= '0;
        else if (mtc0_we && CP0_W_ADDR == CP0_ADDR_COUNT)
            count <= CP0_W_DATA;
        else
            count <= count + 32'd1;
    end
`endif

    always_comb begin
        CP0_R_DATA = '0;
        if (CP0_R_ADDR == ADDR_STATUS)     CP0_R_DATA = status;
        else if (CP0_R_ADDR == ADDR_CAUSE) CP0_R_DATA = cause;
        else if (CP0_R_ADDR == ADDR_EPC)   CP0_R_DATA = epc;
`ifdef CP0_COUNT_EN
        else if (CP0_R_ADDR == CP0_ADDR_COUNT) CP0_R_DATA = count;
`endif
    end

    assign EPC_OUT  = epc;
    assign EXC_ADDR = CP0_EXC_VECTOR;

endmodule

// File: tb/tb_cp0_write_ctrl.sv
// Directed bench for cp0_write_ctrl; expectations are queued when stimulus is driven
// and popped when the corresponding DUT output is sampled. COUNT checks follow CP0_COUNT_EN.
module tb_cp0_write_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        MTC0 = 1'b0;
    logic [4:0]  CP0_W_ADDR = '0;
    logic [31:0] CP0_W_DATA = '0;
    logic        EXC_REQ = 1'b0;
    logic [4:0]  EXC_CODE = '0;
    logic [31:0] EXC_PC = '0;
    logic        ERET = 1'b0;
    logic [4:0]  CP0_R_ADDR = '0;
    logic [31:0] CP0_R_DATA, EPC_OUT, EXC_ADDR;
    logic        EXC_DONE, BUSY;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    cp0_write_ctrl dut (
        .CLK(CLK), .RST(RST), .MTC0(MTC0), .CP0_W_ADDR(CP0_W_ADDR), .CP0_W_DATA(CP0_W_DATA),
        .EXC_REQ(EXC_REQ), .EXC_CODE(EXC_CODE), .EXC_PC(EXC_PC), .ERET(ERET),
        .CP0_R_ADDR(CP0_R_ADDR), .CP0_R_DATA(CP0_R_DATA), .EPC_OUT(EPC_OUT),
        .EXC_ADDR(EXC_ADDR), .EXC_DONE(EXC_DONE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        logic [31:0] e;
        string t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        CP0_R_ADDR = a;
        #1;
        d = CP0_R_DATA;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] e);
        logic [31:0] d;
        push(tag, e);
        rd(a, d);
        chk(d);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        MTC0 = 1'b1;
        CP0_W_ADDR = a;
        CP0_W_DATA = d;
        tick();
        MTC0 = 1'b0;
    endtask

    // Counts edges until EXC_DONE, drops the request levels in the DONE cycle,
    // then confirms the pulse lasts one cycle and the FSM is idle again.
    task automatic run_seq(input string tag, input int exp_cycles);
        int cnt;
        cnt = -1;
        push(tag, exp_cycles);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (EXC_DONE) begin
                cnt = i;
                break;
            end
        end
        chk(cnt);
        EXC_REQ = 1'b0;
        ERET = 1'b0;
        tick();
        push({tag, "_done_pulse_end"}, 0);
        chk({31'd0, EXC_DONE});
        push({tag, "_busy_end"}, 0);
        chk({31'd0, BUSY});
    endtask

    initial begin
        logic [31:0] d;

        // Async reset without any clock edge.
        #2 RST = 1'b1;
        #1;
        chk_reg("rst_status", 5'd12, 32'h0000_0001);
        chk_reg("rst_cause", 5'd13, 32'h0);
        chk_reg("rst_epc", 5'd14, 32'h0);
        push("rst_busy", 0);      chk({31'd0, BUSY});
        push("rst_done", 0);      chk({31'd0, EXC_DONE});
        push("exc_addr", 32'h0000_0004); chk(EXC_ADDR);
        tick(); tick();
        RST = 1'b0;
        tick();

        // mtc0 STATUS; same-cycle read sees the old value.
        MTC0 = 1'b1; CP0_W_ADDR = 5'd12; CP0_W_DATA = 32'h0000_0F01;
        chk_reg("mtc0_same_cycle_old", 5'd12, 32'h0000_0001);
        tick();
        MTC0 = 1'b0;
        chk_reg("mtc0_status", 5'd12, 32'h0000_0F01);

        // mtc0 to an unimplemented address changes nothing.
        mtc0(5'd7, 32'hDEAD_BEEF);
        chk_reg("drop_status", 5'd12, 32'h0000_0F01);
        chk_reg("drop_cause", 5'd13, 32'h0);
        chk_reg("drop_epc", 5'd14, 32'h0);
        chk_reg("drop_rd7", 5'd7, 32'h0);

        // Syscall.
        EXC_REQ = 1'b1; EXC_CODE = 5'd8; EXC_PC = 32'h0040_0010;
        run_seq("syscall_latency", 3);
        chk_reg("syscall_epc", 5'd14, 32'h0040_0010);
        chk_reg("syscall_cause", 5'd13, 32'h0000_0020);
        chk_reg("syscall_status", 5'd12, 32'h0001_E020);

        // Eret.
        ERET = 1'b1;
        run_seq("eret_latency", 2);
        chk_reg("eret_status", 5'd12, 32'h0000_0F01);
        push("eret_epc_out", 32'h0040_0010); chk(EPC_OUT);

        // Masked break: immediate DONE, registers untouched.
        mtc0(5'd12, 32'h0000_0001);
        EXC_REQ = 1'b1; EXC_CODE = 5'd9; EXC_PC = 32'h0000_1234;
        run_seq("masked_latency", 1);
        chk_reg("masked_status", 5'd12, 32'h0000_0001);
        chk_reg("masked_epc", 5'd14, 32'h0040_0010);
        chk_reg("masked_cause", 5'd13, 32'h0000_0020);

        // Simultaneous EXC_REQ and ERET: exception wins.
        mtc0(5'd12, 32'h0000_0F01);
        EXC_REQ = 1'b1; ERET = 1'b1; EXC_CODE = 5'd8; EXC_PC = 32'h0040_0100;
        run_seq("simul_latency", 3);
        chk_reg("simul_epc", 5'd14, 32'h0040_0100);
        chk_reg("simul_status", 5'd12, 32'h0001_E020);

        // teq enabled only by STATUS[3]; other CAUSE bits hold.
        mtc0(5'd12, 32'h0000_0008);
        mtc0(5'd13, 32'hFFFF_FF83);
        EXC_REQ = 1'b1; EXC_CODE = 5'd13; EXC_PC = 32'h0040_0200;
        run_seq("teq_latency", 3);
        chk_reg("teq_cause", 5'd13, 32'hFFFF_FFB7);
        chk_reg("teq_status", 5'd12, 32'h0000_0100);
        chk_reg("teq_epc", 5'd14, 32'h0040_0200);

        // mtc0 while busy is ignored; reset in EXC_MASK clears everything.
        mtc0(5'd12, 32'h0000_0F01);
        EXC_REQ = 1'b1; EXC_CODE = 5'd8; EXC_PC = 32'h0050_0000;
        tick();
        MTC0 = 1'b1; CP0_W_ADDR = 5'd14; CP0_W_DATA = 32'hFFFF_0000;
        push("busy_flag", 1); chk({31'd0, BUSY});
        tick();
        MTC0 = 1'b0;
        push("busy_mtc0_ignored", 32'h0050_0000); chk(EPC_OUT);
        #2 RST = 1'b1;
        #1;
        chk_reg("midrst_status", 5'd12, 32'h0000_0001);
        chk_reg("midrst_epc", 5'd14, 32'h0);
        chk_reg("midrst_cause", 5'd13, 32'h0);
        push("midrst_busy", 0); chk({31'd0, BUSY});
        EXC_REQ = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        push("post_rst_idle", 0); chk({31'd0, BUSY});

`ifdef CP0_COUNT_EN
        mtc0(5'd9, 32'hFFFF_FFFE);
        chk_reg("count_write", 5'd9, 32'hFFFF_FFFE);
        tick();
        chk_reg("count_max", 5'd9, 32'hFFFF_FFFF);
        tick();
        chk_reg("count_wrap", 5'd9, 32'h0000_0000);
`else
        mtc0(5'd9, 32'h1234_5678);
        chk_reg("count_absent", 5'd9, 32'h0);
`endif
        rd(5'd12, d);
        push("final_status", 32'h0000_0001); chk(d);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
